// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: message-granular round-robin sharing of one serial TX holding register (optional SERIAL_TX_ARB_PRIO0_EN gives requester 0 priority at arbitration)
module serial_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_dat,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        sp_dat,
  output logic              sp_stb,
  input  logic              sp_full,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, LOCK, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] g_q, g_d, rr_q, rr_d, pick, idx, g_nxt;
  logic [15:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  assign g_nxt = (g_q == PW'(NREQ-1)) ? '0 : g_q + 1'b1;
  assign busy = busy_q;
  assign grant = busy_q ? NREQ'(1) << g_q : '0;
  assign sp_stb = (state_q == SEND) && !rst;
  assign sp_dat = sp_stb ? req_dat[{g_q, 3'b000} +: 8] : '0;
  assign req_ack = sp_stb ? grant : '0;
  // first valid requester scanning upward from rr_q with wrap
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = PW'((int'(rr_q) + k) % NREQ);
      if (req_valid[idx]) pick = idx;
    end
`ifdef SERIAL_TX_ARB_PRIO0_EN
    if (req_valid[0]) pick = '0;
`endif
  end
  // next-state: grant on request, strobe when owner ready, release on last byte or stall timeout
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        g_d = pick;
        busy_d = 1'b1;
        cnt_d = '0;
        state_d = LOCK;
      end
      LOCK: if (req_valid[g_q] && !sp_full) state_d = SEND;
        else if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
          state_d = IDLE;
          busy_d = 1'b0;
          cnt_d = '0;
          rr_d = g_nxt;
        end else cnt_d = cnt_q + 16'd1;
      SEND: begin
        cnt_d = '0;
        state_d = req_last[g_q] ? IDLE : GAP;
        busy_d = !req_last[g_q];
        rr_d = req_last[g_q] ? g_nxt : rr_q;
      end
      default: state_d = LOCK;
    endcase
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed scenarios plus randomized traffic checked against a cycle-timing model
module tb_serial_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TO = 24;
  logic clk, rst, sp_stb, sp_full, busy;
  logic [NREQ-1:0] req_valid, req_last, req_ack, grant;
  logic [8*NREQ-1:0] req_dat;
  logic [7:0] sp_dat;
  int n_cmp, n_bad, cycle;
  logic [8:0] prog [NREQ][$];
  logic [NREQ-1:0] ack_seen;
  int s_idx[$], s_dat[$], s_cyc[$];

  serial_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dat(req_dat), .req_last(req_last),
    .req_ack(req_ack), .sp_dat(sp_dat), .sp_stb(sp_stb), .sp_full(sp_full), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cycle);
    end
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] v, int rr);
`ifdef SERIAL_TX_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  // model: owner, rr pointer, earliest cycle the owner may be serviced, stall count
  int m_own = -1, m_rr = 0, m_stall = 0, m_ready = 0;
  bit m_stb = 0, m_ok = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_own = -1; m_rr = 0; m_stall = 0; m_stb = 0; m_ok = 1;
    end else if (m_stb) begin
      m_stb = 0; m_stall = 0;
      if (req_last[m_own]) begin m_rr = (m_own + 1) % NREQ; m_own = -1; end
      else m_ready = cycle + 2;
    end else if (m_own < 0) begin
      if (|req_valid) begin m_own = rr_pick(req_valid, m_rr); m_ready = cycle + 1; m_stall = 0; end
    end else if (cycle >= m_ready) begin
      if (req_valid[m_own] && !sp_full) m_stb = 1;
      else begin
        m_stall++;
        if (m_stall == TO) begin m_rr = (m_own + 1) % NREQ; m_own = -1; end
      end
    end
    cycle++;
  end

  always @(negedge clk) begin
    ack_seen = req_ack;
    if (sp_stb) begin s_idx.push_back($clog2(req_ack)); s_dat.push_back(int'(sp_dat)); s_cyc.push_back(cycle); end
    if (m_ok) begin
      logic xs;
      xs = m_stb && !rst;
      chk("stb", sp_stb, xs);
      chk("dat", sp_dat, xs ? req_dat[8*m_own +: 8] : 8'h0);
      chk("ack", req_ack, xs ? (32'd1 << m_own) : 0);
      chk("grant", grant, m_own >= 0 ? (32'd1 << m_own) : 0);
      chk("busy", busy, m_own >= 0);
    end
  end

  task automatic present(int i);
    logic [8:0] b;
    if (prog[i].size() > 0) begin
      b = prog[i].pop_front();
      req_valid[i] = 1'b1; req_dat[8*i +: 8] = b[7:0]; req_last[i] = b[8];
    end else req_valid[i] = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (ack_seen[i]) present(i);
  endtask

  task automatic goto(int k);
    while (cycle < k) cyc();
  endtask

  task automatic wait_stb(int want, int lim);
    int t = 0;
    while (s_dat.size() < want && t < lim) begin cyc(); t++; end
    chk("wait_stb", s_dat.size(), want);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; sp_full = 1'b0;
    for (int i = 0; i < NREQ; i++) prog[i].delete();
    cyc(); cyc();
    rst = 1'b0;
    s_idx.delete(); s_dat.delete(); s_cyc.delete();
  endtask

  initial begin
    int c0, s, r;
    rst = 1'b1; req_valid = '0; req_dat = '0; req_last = '0; sp_full = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_stb", sp_stb, 0); chk("rst_dat", sp_dat, 0);
    cyc(); c0 = cycle;
    prog[1].push_back({1'b1, 8'h41}); present(1);
    goto(c0 + 1); @(negedge clk);
    chk("t2_grant", grant, 4'b0010); chk("t2_busy", busy, 1);
    goto(c0 + 2); @(negedge clk);
    chk("t2_stb", sp_stb, 1); chk("t2_dat", sp_dat, 8'h41); chk("t2_ack", req_ack, 4'b0010);
    goto(c0 + 3); @(negedge clk);
    chk("t2_idle", busy, 0); chk("t2_grant0", grant, 0);
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      prog[i].push_back({1'b1, 8'(8'hA0 + i)}); prog[i].push_back({1'b1, 8'(8'hA0 + i)});
      present(i);
    end
    wait_stb(5, 40);
    if (s_idx.size() >= 5) begin
      for (int j = 0; j < 5; j++) chk("t3_order", s_idx[j], j % 4);
      chk("t3_space", s_cyc[1] - s_cyc[0], 3); chk("t3_dat", s_dat[4], 8'hA0);
    end
    do_reset();
    prog[2].push_back({1'b0, 8'h10}); prog[2].push_back({1'b0, 8'h11}); prog[2].push_back({1'b1, 8'h12});
    prog[0].push_back({1'b1, 8'h55});
    present(2); cyc(); present(0);
    wait_stb(4, 40);
    if (s_dat.size() >= 4) begin
      chk("t4_b0", s_dat[0], 8'h10); chk("t4_b1", s_dat[1], 8'h11); chk("t4_b2", s_dat[2], 8'h12); chk("t4_b3", s_dat[3], 8'h55);
      chk("t4_sp1", s_cyc[1] - s_cyc[0], 3); chk("t4_sp2", s_cyc[2] - s_cyc[1], 3);
    end
    do_reset();
    prog[0].push_back({1'b0, 8'h33}); prog[0].push_back({1'b1, 8'h34}); present(0);
    wait_stb(1, 20);
    sp_full = 1'b1; c0 = cycle;
    goto(c0 + 20);
    sp_full = 1'b0; r = cycle;
    @(negedge clk);
    chk("t5_nostb", s_dat.size(), 1); chk("t5_busy", busy, 1);
    wait_stb(2, 10);
    if (s_dat.size() >= 2) begin chk("t5_within2", (s_cyc[1] - r) <= 2, 1); chk("t5_dat", s_dat[1], 8'h34); end
    do_reset();
    prog[3].push_back({1'b0, 8'h70}); present(3);
    wait_stb(1, 20);
    s = s_cyc[0];
    prog[1].push_back({1'b1, 8'h81}); prog[2].push_back({1'b1, 8'h82}); present(1); present(2);
    goto(s + 1 + TO); @(negedge clk); chk("t6_held", grant, 4'b1000);
    goto(s + 2 + TO); @(negedge clk); chk("t6_clear", grant, 0); chk("t6_busy", busy, 0);
    goto(s + 3 + TO); @(negedge clk); chk("t6_next", grant, 4'b0010);
    do_reset();
    prog[0].push_back({1'b0, 8'h21}); prog[0].push_back({1'b1, 8'h22}); present(0);
    wait_stb(1, 20);
    rst = 1'b1;
    @(negedge clk); chk("t7_gap", sp_stb, 0);
    cyc(); rst = 1'b0;
    @(negedge clk); chk("t7_grant", grant, 0); chk("t7_busy", busy, 0); chk("t7_stb", sp_stb, 0);
    do_reset();
    prog[1].push_back({1'b1, 8'h90}); present(1);
    wait_stb(1, 20);
    s = s_cyc[0];
    prog[0].push_back({1'b1, 8'h91}); prog[2].push_back({1'b1, 8'h92}); present(0); present(2);
    goto(s + 2); @(negedge clk);
`ifdef SERIAL_TX_ARB_PRIO0_EN
    chk("t8_prio", grant, 4'b0001);
`else
    chk("t8_rr", grant, 4'b0100);
`endif
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cyc();
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, n < 2000 ? 2 : 40) == 0) begin
          req_valid[i] = 1'b1; req_dat[8*i +: 8] = 8'($urandom); req_last[i] = ($urandom_range(0, 2) == 0);
        end
      sp_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
